// File: rtl/pin_entry_driver_if.sv
// Host/checker-side bus of pin_entry_driver.
// Defining PIN_ENTRY_STATS_EN adds the pass/fail counters.
interface pin_entry_driver_if;
  logic       start;
  logic [7:0] pin;
  logic       correct;
  logic       incorrect;
  logic       bug;
  logic [3:0] digit_switches;
  logic       submit;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic       timeout;
`ifdef PIN_ENTRY_STATS_EN
  logic [7:0] pass_count;
  logic [7:0] fail_count;
`endif

  modport master (
    input  start, pin, correct, incorrect, bug,
`ifdef PIN_ENTRY_STATS_EN
    output pass_count, fail_count,
`endif
    output digit_switches, submit, busy, done, pass, fail, timeout
  );

  modport slave (
    output start, pin, correct, incorrect, bug,
`ifdef PIN_ENTRY_STATS_EN
    input  pass_count, fail_count,
`endif
    input  digit_switches, submit, busy, done, pass, fail, timeout
  );
endinterface

// File: rtl/pin_entry_driver.sv
// Drives a 4-digit PIN one-hot into a DebitPin checker, then reports pass/fail/timeout.
// Optional macro PIN_ENTRY_STATS_EN adds saturating pass_count/fail_count outputs.
module pin_entry_driver #(
  parameter int SETUP_CYCLES   = 1,
  parameter int GAP_CYCLES     = 2,
  parameter int RESULT_TIMEOUT = 16
) (
  input logic                clk,
  input logic                reset,
  pin_entry_driver_if.master bus
);
  localparam int TW_R = $clog2(RESULT_TIMEOUT + 1);
  localparam int TW_S = $clog2(SETUP_CYCLES + 1);
  localparam int TW_G = $clog2(GAP_CYCLES + 1);
  // One timer paces setup, gap and the verdict wait, so it spans the widest of them.
  localparam int TW = (TW_R >= TW_S && TW_R >= TW_G) ? TW_R : ((TW_S >= TW_G) ? TW_S : TW_G);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(RESULT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DRIVE, STROBE, GAP, WAIT_RESULT, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          pass_q, pass_n, fail_q, fail_n, tmo_q, tmo_n, done_q, done_n;
  logic          verdict;

  assign verdict = bus.correct | bus.incorrect | bus.bug;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      sh     <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      tmo_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      idx    <= idx_n;
      sh     <= sh_n;
      pass_q <= pass_n;
      fail_q <= fail_n;
      tmo_q  <= tmo_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    sh_n    = sh;
    pass_n  = pass_q;
    fail_n  = fail_q;
    tmo_n   = tmo_q;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          sh_n    = bus.pin;
          idx_n   = '0;
          timer_n = '0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          tmo_n   = 1'b0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (timer == SETUP_LAST) begin
          timer_n = '0;
          state_n = STROBE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STROBE: begin
        timer_n = '0;
        state_n = GAP;
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          if (idx != 2'd3) begin
            idx_n   = idx + 2'd1;
            sh_n    = {sh[5:0], 2'b00};
            state_n = DRIVE;
          end else begin
            state_n = WAIT_RESULT;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_RESULT: begin
        // A verdict on the final wait cycle beats the timeout.
        if (verdict) begin
          fail_n  = bus.incorrect | bus.bug;
          pass_n  = bus.correct & ~(bus.incorrect | bus.bug);
          done_n  = 1'b1;
          state_n = DONE;
        end else if (timer == WAIT_LAST) begin
          tmo_n   = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.digit_switches = (state inside {DRIVE, STROBE, GAP}) ? (4'b0001 << sh[7:6]) : 4'b0000;
  assign bus.submit         = (state == STROBE);
  assign bus.busy           = state inside {DRIVE, STROBE, GAP, WAIT_RESULT};
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail           = fail_q;
  assign bus.timeout        = tmo_q;

`ifdef PIN_ENTRY_STATS_EN
  logic [7:0] pass_cnt, fail_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (done_n) begin
      if (pass_n && pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
      if (fail_n && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
    end
  end

  assign bus.pass_count = pass_cnt;
  assign bus.fail_count = fail_cnt;
`endif
endmodule
